// File: rtl/seq_pkg.sv
// Shared step type, FSM states and HID keycode constants for the pattern sequencer.
package seq_pkg;

    localparam int unsigned KEY_W = 8;
    localparam int unsigned DUR_W = 8;

    typedef struct packed {
        logic [KEY_W-1:0] keycode;
        logic [DUR_W-1:0] dur;
    } step_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // HID usage codes of the keys the note mapper understands (TAB = C4 .. LBRACE = B4)
    localparam logic [KEY_W-1:0] KEY_NONE   = 8'd0;
    localparam logic [KEY_W-1:0] KEY_TAB    = 8'd43;
    localparam logic [KEY_W-1:0] KEY_Q      = 8'd20;
    localparam logic [KEY_W-1:0] KEY_W_KEY  = 8'd26;
    localparam logic [KEY_W-1:0] KEY_E      = 8'd8;
    localparam logic [KEY_W-1:0] KEY_R      = 8'd21;
    localparam logic [KEY_W-1:0] KEY_T      = 8'd23;
    localparam logic [KEY_W-1:0] KEY_Y      = 8'd28;
    localparam logic [KEY_W-1:0] KEY_U      = 8'd24;
    localparam logic [KEY_W-1:0] KEY_I      = 8'd12;
    localparam logic [KEY_W-1:0] KEY_O      = 8'd18;
    localparam logic [KEY_W-1:0] KEY_P      = 8'd19;
    localparam logic [KEY_W-1:0] KEY_LBRACE = 8'd47;

endpackage

// File: rtl/seq_tick_gen.sv
// Sequencer time base: one-cycle tick strobe every TICK_DIV cycles, restartable by clr.
module seq_tick_gen #(
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(TICK_DIV - 2);

    logic [CW-1:0] cnt;

    // tick is registered one count early so it is high while cnt sits at CNT_LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            tick <= (cnt == CNT_PRE);
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Autonomous keycode source playing a programmable (keycode, duration) pattern.
// Build option SEQ_GAP_EN: insert a one-tick silent gap between steps so repeated keys retrigger.
module note_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned STEPS    = 16,
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [7:0]               wr_keycode,
    input  logic [7:0]               wr_dur,
    output logic [7:0]               keycode_out,
    output logic                     busy,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     done
);

    localparam int unsigned AW = $clog2(STEPS);

    step_t            mem [STEPS];
    state_t           state, state_d;
    logic [KEY_W-1:0] key_d;
    logic [DUR_W-1:0] rem, rem_d;
    logic [AW-1:0]    step_d;
    logic             busy_d;
    logic             done_d;
    logic             tick;

    logic             tick_clr_c;
    logic             load_c;
    logic [AW-1:0]    load_idx_c;
    logic             advance_c;
    logic             end_c;
    logic [AW-1:0]    nxt_c;
    logic             last_c;

    assign nxt_c  = step_idx + AW'(1);
    assign last_c = (step_idx == AW'(STEPS - 1));

    seq_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr_c),
        .tick  (tick)
    );

    // Pattern store; loads read it combinationally, so a same-cycle write is seen only afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STEPS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= {wr_keycode, wr_dur};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            keycode_out <= KEY_NONE;
            rem         <= '0;
            step_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            keycode_out <= key_d;
            rem         <= rem_d;
            step_idx    <= step_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Next state: stop beats start, start beats playback; loads and pattern end are resolved last
    always_comb begin
        state_d    = state;
        key_d      = keycode_out;
        rem_d      = rem;
        step_d     = step_idx;
        done_d     = 1'b0;
        load_c     = 1'b0;
        load_idx_c = '0;
        advance_c  = 1'b0;
        end_c      = 1'b0;
        tick_clr_c = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            key_d   = KEY_NONE;
        end else if (start) begin
            load_c     = 1'b1;
            load_idx_c = '0;
            tick_clr_c = 1'b1;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (tick) begin
                        rem_d = rem - DUR_W'(1);
                        if (rem == DUR_W'(1)) begin
`ifdef SEQ_GAP_EN
                            state_d = ST_GAP;
                            key_d   = KEY_NONE;
`else
                            advance_c = 1'b1;
`endif
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        advance_c = 1'b1;
                    end
                end
                default: begin
                end
            endcase

            if (advance_c) begin
                if (last_c || (mem[nxt_c].dur == '0)) begin
                    if (loop) begin
                        load_c     = 1'b1;
                        load_idx_c = '0;
                    end else begin
                        end_c = 1'b1;
                    end
                end else begin
                    load_c     = 1'b1;
                    load_idx_c = nxt_c;
                end
            end
        end

        if (end_c) begin
            state_d = ST_IDLE;
            key_d   = KEY_NONE;
            done_d  = 1'b1;
        end

        // A zero-duration step is the end marker, even when it is step 0
        if (load_c) begin
            step_d = load_idx_c;
            if (mem[load_idx_c].dur == '0) begin
                state_d = ST_IDLE;
                key_d   = KEY_NONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_PLAY;
                key_d   = mem[load_idx_c].keycode;
                rem_d   = mem[load_idx_c].dur;
            end
        end

        if (state_d == ST_IDLE) begin
            tick_clr_c = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed literal patterns plus random traffic against a timeline model.
module tb_note_sequencer;

    localparam int STEPS = 8;
    localparam int TD    = 4;
`ifdef SEQ_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_keycode = 8'd0;
    logic [7:0] wr_dur = 8'd0;
    logic [7:0] keycode_out;
    logic       busy;
    logic [2:0] step_idx;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    note_sequencer #(
        .STEPS    (STEPS),
        .TICK_DIV (TD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .loop        (loop),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_keycode  (wr_keycode),
        .wr_dur      (wr_dur),
        .keycode_out (keycode_out),
        .busy        (busy),
        .step_idx    (step_idx),
        .done        (done)
    );

    // Timeline model: a step lasts (dur+GAP)*TD cycles from its load; the key sounds for the first dur*TD
    logic [7:0] m_key [STEPS];
    logic [7:0] m_dur [STEPS];
    bit         m_active;
    bit         m_done;
    int         m_s;
    int         m_t;
    logic [7:0] m_ckey;
    logic [7:0] m_cdur;

    function automatic void m_load(input int i);
        m_s = i;
        if (m_dur[i] == 8'd0) begin
            m_active = 1'b0;
            m_done   = 1'b1;
        end else begin
            m_active = 1'b1;
            m_ckey   = m_key[i];
            m_cdur   = m_dur[i];
            m_t      = 0;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                m_key[i] = 8'd0;
                m_dur[i] = 8'd0;
            end
            m_active = 1'b0;
            m_done   = 1'b0;
            m_s      = 0;
            m_t      = 0;
            m_ckey   = 8'd0;
            m_cdur   = 8'd0;
        end else begin
            m_done = 1'b0;
            if (stop) begin
                m_active = 1'b0;
            end else if (start) begin
                m_load(0);
            end else if (m_active) begin
                m_t++;
                if (m_t == (int'(m_cdur) + GAP) * TD) begin
                    if (m_s == STEPS - 1 || m_dur[(m_s + 1) % STEPS] == 8'd0) begin
                        if (loop) begin
                            m_load(0);
                        end else begin
                            m_active = 1'b0;
                            m_done   = 1'b1;
                        end
                    end else begin
                        m_load(m_s + 1);
                    end
                end
            end
            if (wr_en) begin
                m_key[wr_addr] = wr_keycode;
                m_dur[wr_addr] = wr_dur;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle out of reset: DUT against model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_key", 32'(keycode_out),
                32'((m_active && m_t < int'(m_cdur) * TD) ? m_ckey : 8'd0));
            chk("model_busy", 32'(busy), 32'(m_active));
            chk("model_step", 32'(step_idx), 32'(m_s));
            chk("model_done", 32'(done), 32'(m_done));
        end
    end

    task automatic wr_step(input int a, input int k, input int d);
        @(posedge clk) #1;
        wr_en      = 1'b1;
        wr_addr    = 3'(a);
        wr_keycode = 8'(k);
        wr_dur     = 8'(d);
        @(posedge clk) #1;
        wr_en      = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk) #1;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk) #1;
        stop = 1'b1;
        @(posedge clk) #1;
        stop = 1'b0;
    endtask

    task automatic expect_keys(input string name, input logic [7:0] q[$]);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            chk(name, 32'(keycode_out), 32'(q[k]));
            chk({name, "_busy"}, 32'(busy), 32'd1);
            chk({name, "_nodone"}, 32'(done), 32'd0);
        end
    endtask

    task automatic expect_end(input string name);
        @(negedge clk);
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_key"}, 32'(keycode_out), 32'd0);
        @(negedge clk);
        chk({name, "_done_drop"}, 32'(done), 32'd0);
    endtask

    task automatic push_n(inout logic [7:0] q[$], input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back(v);
        end
    endtask

    logic [7:0] q[$];
    logic [7:0] keyset [4];

    initial begin
        keyset[0] = 8'd43;
        keyset[1] = 8'd20;
        keyset[2] = 8'd24;
        keyset[3] = 8'd0;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_key", 32'(keycode_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_step", 32'(step_idx), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Two notes then end marker, single shot
        wr_step(0, 43, 2);
        wr_step(1, 20, 1);
        wr_step(2, 0, 0);
        loop = 1'b0;
        pulse_start();
        q = {};
        push_n(q, 8'd43, 2 * TD);
        push_n(q, 8'd0, GAP * TD);
        push_n(q, 8'd20, TD);
        push_n(q, 8'd0, GAP * TD);
        expect_keys("oneshot", q);
        expect_end("oneshot");

        // Same pattern looping: step 0 comes back, then stop aborts silently
        loop = 1'b1;
        pulse_start();
        q = {};
        push_n(q, 8'd43, 2 * TD);
        push_n(q, 8'd0, GAP * TD);
        push_n(q, 8'd20, TD);
        push_n(q, 8'd0, GAP * TD);
        push_n(q, 8'd43, 1);
        expect_keys("loop", q);
        chk("loop_step0", 32'(step_idx), 32'd0);
        pulse_stop();
        @(negedge clk);
        chk("stop_key", 32'(keycode_out), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        loop = 1'b0;

        // start+stop together while idle, then while playing
        @(posedge clk) #1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        chk("ss_idle_busy", 32'(busy), 32'd0);
        chk("ss_idle_key", 32'(keycode_out), 32'd0);
        pulse_start();
        repeat (2) @(negedge clk);
        @(posedge clk) #1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        chk("ss_play_busy", 32'(busy), 32'd0);
        chk("ss_play_key", 32'(keycode_out), 32'd0);
        chk("ss_play_done", 32'(done), 32'd0);

        // Restart from the middle of step 1
        pulse_start();
        repeat (2 * TD + GAP * TD + 1) @(negedge clk);
        chk("mid_step1", 32'(step_idx), 32'd1);
        chk("mid_key20", 32'(keycode_out), 32'd20);
        pulse_start();
        @(negedge clk);
        chk("restart_key", 32'(keycode_out), 32'd43);
        chk("restart_step", 32'(step_idx), 32'd0);
        pulse_stop();

        // Empty pattern: done right away, never busy
        wr_step(0, 43, 0);
        pulse_start();
        @(negedge clk);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_key", 32'(keycode_out), 32'd0);
        @(negedge clk);
        chk("empty_done_drop", 32'(done), 32'd0);

        // Full-depth pattern ends on the last step without a marker
        for (int i = 0; i < STEPS; i++) begin
            wr_step(i, 26, 1);
        end
        pulse_start();
        q = {};
        for (int i = 0; i < STEPS; i++) begin
            push_n(q, 8'd26, TD);
            push_n(q, 8'd0, GAP * TD);
        end
        expect_keys("full", q);
        expect_end("full");

        // Identical consecutive keys: merged without a gap, retriggered with one
        wr_step(0, 24, 1);
        wr_step(1, 24, 1);
        wr_step(2, 0, 0);
        pulse_start();
        q = {};
        push_n(q, 8'd24, TD);
        push_n(q, 8'd0, GAP * TD);
        push_n(q, 8'd24, TD);
        push_n(q, 8'd0, GAP * TD);
        expect_keys("repeat", q);
        expect_end("repeat");

        // Random traffic: writes during playback, start/stop collisions, loop toggling
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk) #1;
            start      = ($urandom_range(0, 39) == 0);
            stop       = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 199) == 0) loop = ~loop;
            wr_en      = ($urandom_range(0, 7) == 0);
            wr_addr    = 3'($urandom_range(0, STEPS - 1));
            wr_keycode = keyset[$urandom_range(0, 3)];
            wr_dur     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
        end
        @(posedge clk) #1;
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
